// File: rtl/agu_pkg.sv
// Shared constants and state encoding for the split-beat address-generation stage.
package agu_pkg;

  localparam int unsigned OP_STORE = 3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;

  localparam logic [1:0] PART_SINGLE = 2'b00;
  localparam logic [1:0] PART_LO     = 2'b01;
  localparam logic [1:0] PART_HI     = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } agu_state_e;

  // Unshifted byte-enable pattern for an access size (illegal size yields a full word).
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_mask = 4'h1;
      SZ_HALF: size_mask = 4'h3;
      SZ_WORD: size_mask = 4'hF;
      default: size_mask = 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/agu_split_skdbf.sv
// One-entry skid buffer: the head is the live input when empty, else the held entry.
module skdbf #(
  parameter int unsigned W = 80
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_vld,
  output logic         o_busy,
  input  logic [W-1:0] i_data,
  output logic         o_vld_c,
  output logic [W-1:0] o_data_c,
  input  logic         i_pop
);

  logic         r_full;
  logic [W-1:0] r_data;

  assign o_busy   = r_full;
  assign o_vld_c  = r_full | i_vld;
  assign o_data_c = r_full ? r_data : i_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_flush) begin
      r_full <= 1'b0;
    end else if (r_full) begin
      if (i_pop) r_full <= 1'b0;
    end else if (i_vld && !i_pop) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end
  end

endmodule

// File: rtl/agu_split.sv
// Address generation with byte masks, shifted store data and two-beat splitting of
// word-crossing accesses; faults raise a one-cycle misaligned exception.
module agu_split
  import agu_pkg::*;
#(
  parameter int unsigned ROB_W    = 6,
  parameter int unsigned PREG_W   = 6,
  parameter int unsigned IO_BIT   = 31,
  parameter int unsigned SPLIT_EN = 1
) (
  input  logic              cpu_clock_i,
  input  logic              cpu_resetn_i,
  input  logic              flush_i,
  input  logic              lsu_vld_i,
  output logic              lsu_busy_o,
  input  logic [ROB_W-1:0]  lsu_rob_i,
  input  logic [3:0]        lsu_op_i,
  input  logic [31:0]       lsu_data_i,
  input  logic [31:0]       lsu_addr_i,
  input  logic [PREG_W-1:0] lsu_dest_i,
  input  logic              lq_full_i,
  input  logic              enqueue_full_i,
  output logic              lq_valid_o,
  output logic [31:0]       lq_addr_o,
  output logic [2:0]        lq_ld_type_o,
  output logic [PREG_W-1:0] lq_dest_o,
  output logic [ROB_W-1:0]  lq_rob_o,
  output logic [1:0]        lq_part_o,
  output logic              enqueue_en_o,
  output logic [29:0]       enqueue_address_o,
  output logic [31:0]       enqueue_data_o,
  output logic [3:0]        enqueue_bm_o,
  output logic              enqueue_io_o,
  output logic [ROB_W-1:0]  enqueue_rob_o,
  output logic [29:0]       conflict_address_o,
  output logic [3:0]        conflict_bm_o,
  output logic              excp_valid,
  output logic [31:0]       excp_pc,
  output logic [3:0]        excp_code_o,
  output logic [ROB_W-1:0]  excp_rob
);

  localparam int unsigned PL_W     = ROB_W + 4 + 32 + 32 + PREG_W;
  localparam logic        L_SPLIT  = 1'(SPLIT_EN != 0);

  logic              w_h_vld;
  logic [PL_W-1:0]   w_head;
  logic [ROB_W-1:0]  w_h_rob;
  logic [3:0]        w_h_op;
  logic [31:0]       w_h_data;
  logic [31:0]       w_h_addr;
  logic [PREG_W-1:0] w_h_dest;
  logic              w_pop;

  skdbf #(.W(PL_W)) u_skdbf (
    .i_clk    (cpu_clock_i),
    .i_rst_n  (cpu_resetn_i),
    .i_flush  (flush_i),
    .i_vld    (lsu_vld_i),
    .o_busy   (lsu_busy_o),
    .i_data   ({lsu_rob_i, lsu_op_i, lsu_data_i, lsu_addr_i, lsu_dest_i}),
    .o_vld_c  (w_h_vld),
    .o_data_c (w_head),
    .i_pop    (w_pop)
  );

  assign {w_h_rob, w_h_op, w_h_data, w_h_addr, w_h_dest} = w_head;

  // Mask/shift of the head op, computed once and sliced per beat.
  logic        w_adv;
  logic        w_store;
  logic [1:0]  w_size;
  logic [6:0]  w_m7;
  logic [55:0] w_d56;
  logic        w_cross;
  logic [29:0] w_word;
  logic [29:0] w_word_p1;
  logic        w_fault;

  assign w_adv     = !lq_full_i && !enqueue_full_i;
  assign w_store   = w_h_op[OP_STORE];
  assign w_size    = w_h_op[1:0];
  assign w_m7      = {3'b000, size_mask(w_size)} << w_h_addr[1:0];
  assign w_d56     = {24'h0, w_h_data} << {w_h_addr[1:0], 3'b000};
  assign w_cross   = |w_m7[6:4];
  assign w_word    = w_h_addr[31:2];
  assign w_word_p1 = w_word + 30'd1;
  assign w_fault   = (w_cross && (!L_SPLIT || w_h_addr[IO_BIT] || (&w_word)))
                   || (w_size == SZ_ILL);

  agu_state_e  r_state;
  agu_state_e  w_state_nxt;
  logic        w_beat;
  logic        w_excp;
  logic [29:0] w_b_word;
  logic [3:0]  w_b_bm;
  logic [31:0] w_b_data;
  logic [31:0] w_b_addr;
  logic [1:0]  w_b_part;

  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) r_state <= ST_IDLE;
    else               r_state <= w_state_nxt;
  end

  // Next state, pop and the beat to issue this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_beat      = 1'b0;
    w_excp      = 1'b0;
    w_b_word    = w_word;
    w_b_bm      = w_m7[3:0];
    w_b_data    = w_d56[31:0];
    w_b_addr    = w_h_addr;
    w_b_part    = PART_SINGLE;
    if (flush_i) begin
      w_state_nxt = ST_IDLE;
    end else if (w_h_vld && w_adv) begin
      case (r_state)
        ST_IDLE: begin
          if (w_fault) begin
            w_pop  = 1'b1;
            w_excp = 1'b1;
          end else if (w_cross) begin
            w_beat      = 1'b1;
            w_b_part    = PART_LO;
            w_state_nxt = ST_SPLIT;
          end else begin
            w_beat = 1'b1;
            w_pop  = 1'b1;
          end
        end
        ST_SPLIT: begin
          w_beat      = 1'b1;
          w_pop       = 1'b1;
          w_b_word    = w_word_p1;
          w_b_bm      = {1'b0, w_m7[6:4]};
          w_b_data    = {8'h00, w_d56[55:32]};
          w_b_addr    = {w_word_p1, 2'b00};
          w_b_part    = PART_HI;
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  logic              r_lq_valid;
  logic [31:0]       r_lq_addr;
  logic [2:0]        r_lq_type;
  logic [PREG_W-1:0] r_lq_dest;
  logic [ROB_W-1:0]  r_lq_rob;
  logic [1:0]        r_lq_part;
  logic              r_enq_en;
  logic [29:0]       r_enq_addr;
  logic [31:0]       r_enq_data;
  logic [3:0]        r_enq_bm;
  logic              r_enq_io;
  logic [ROB_W-1:0]  r_enq_rob;
  logic [29:0]       r_cf_addr;
  logic [3:0]        r_cf_bm;
  logic              r_excp_valid;
  logic [31:0]       r_excp_pc;
  logic [3:0]        r_excp_code;
  logic [ROB_W-1:0]  r_excp_rob;

  // Output registers: valids hold under their own full, payloads change only on a new beat.
  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      r_lq_valid   <= 1'b0;
      r_lq_addr    <= '0;
      r_lq_type    <= '0;
      r_lq_dest    <= '0;
      r_lq_rob     <= '0;
      r_lq_part    <= '0;
      r_enq_en     <= 1'b0;
      r_enq_addr   <= '0;
      r_enq_data   <= '0;
      r_enq_bm     <= '0;
      r_enq_io     <= 1'b0;
      r_enq_rob    <= '0;
      r_cf_addr    <= '0;
      r_cf_bm      <= '0;
      r_excp_valid <= 1'b0;
      r_excp_pc    <= '0;
      r_excp_code  <= '0;
      r_excp_rob   <= '0;
    end else if (flush_i) begin
      r_lq_valid   <= 1'b0;
      r_enq_en     <= 1'b0;
      r_excp_valid <= 1'b0;
    end else begin
      r_excp_valid <= w_excp;
      if (w_excp) begin
        r_excp_pc   <= w_h_addr;
        r_excp_code <= w_store ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
        r_excp_rob  <= w_h_rob;
      end
      if (w_beat && !w_store) begin
        r_lq_valid <= 1'b1;
        r_lq_addr  <= w_b_addr;
        r_lq_type  <= w_h_op[2:0];
        r_lq_dest  <= w_h_dest;
        r_lq_rob   <= w_h_rob;
        r_lq_part  <= w_b_part;
        r_cf_addr  <= w_b_word;
        r_cf_bm    <= w_b_bm;
      end else if (!lq_full_i) begin
        r_lq_valid <= 1'b0;
      end
      if (w_beat && w_store) begin
        r_enq_en   <= 1'b1;
        r_enq_addr <= w_b_word;
        r_enq_data <= w_b_data;
        r_enq_bm   <= w_b_bm;
        r_enq_io   <= w_h_addr[IO_BIT];
        r_enq_rob  <= w_h_rob;
      end else if (!enqueue_full_i) begin
        r_enq_en <= 1'b0;
      end
    end
  end

  assign lq_valid_o         = r_lq_valid;
  assign lq_addr_o          = r_lq_addr;
  assign lq_ld_type_o       = r_lq_type;
  assign lq_dest_o          = r_lq_dest;
  assign lq_rob_o           = r_lq_rob;
  assign lq_part_o          = r_lq_part;
  assign enqueue_en_o       = r_enq_en;
  assign enqueue_address_o  = r_enq_addr;
  assign enqueue_data_o     = r_enq_data;
  assign enqueue_bm_o       = r_enq_bm;
  assign enqueue_io_o       = r_enq_io;
  assign enqueue_rob_o      = r_enq_rob;
  assign conflict_address_o = r_cf_addr;
  assign conflict_bm_o      = r_cf_bm;
  assign excp_valid         = r_excp_valid;
  assign excp_pc            = r_excp_pc;
  assign excp_code_o        = r_excp_code;
  assign excp_rob           = r_excp_rob;

endmodule

// File: tb/tb_agu_split.sv
// Directed bench for agu_split: one splitting instance plus a SPLIT_EN=0 instance on shared inputs.
module tb_agu_split;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        vld = 1'b0;
  logic [5:0]  rob = '0;
  logic [3:0]  op = '0;
  logic [31:0] data = '0;
  logic [31:0] addr = '0;
  logic [5:0]  dest = '0;
  logic        lq_full = 1'b0;
  logic        enq_full = 1'b0;

  logic        busy, lq_valid, enq_en, enq_io, x_valid;
  logic [31:0] lq_addr, enq_data, x_pc;
  logic [2:0]  lq_type;
  logic [5:0]  lq_dest, lq_rob, enq_rob, x_rob;
  logic [1:0]  lq_part;
  logic [29:0] enq_addr, cf_addr;
  logic [3:0]  enq_bm, cf_bm, x_code;

  logic        d0_busy, d0_lq_valid, d0_enq_en, d0_enq_io, d0_x_valid;
  logic [31:0] d0_lq_addr, d0_enq_data, d0_x_pc;
  logic [2:0]  d0_lq_type;
  logic [5:0]  d0_lq_dest, d0_lq_rob, d0_enq_rob, d0_x_rob;
  logic [1:0]  d0_lq_part;
  logic [29:0] d0_enq_addr, d0_cf_addr;
  logic [3:0]  d0_enq_bm, d0_cf_bm, d0_x_code;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  agu_split #(.ROB_W(6), .PREG_W(6), .IO_BIT(31), .SPLIT_EN(1)) u_dut (
    .cpu_clock_i(clk), .cpu_resetn_i(rst_n), .flush_i(flush),
    .lsu_vld_i(vld), .lsu_busy_o(busy), .lsu_rob_i(rob), .lsu_op_i(op),
    .lsu_data_i(data), .lsu_addr_i(addr), .lsu_dest_i(dest),
    .lq_full_i(lq_full), .enqueue_full_i(enq_full),
    .lq_valid_o(lq_valid), .lq_addr_o(lq_addr), .lq_ld_type_o(lq_type),
    .lq_dest_o(lq_dest), .lq_rob_o(lq_rob), .lq_part_o(lq_part),
    .enqueue_en_o(enq_en), .enqueue_address_o(enq_addr), .enqueue_data_o(enq_data),
    .enqueue_bm_o(enq_bm), .enqueue_io_o(enq_io), .enqueue_rob_o(enq_rob),
    .conflict_address_o(cf_addr), .conflict_bm_o(cf_bm),
    .excp_valid(x_valid), .excp_pc(x_pc), .excp_code_o(x_code), .excp_rob(x_rob)
  );

  agu_split #(.ROB_W(6), .PREG_W(6), .IO_BIT(31), .SPLIT_EN(0)) u_dut0 (
    .cpu_clock_i(clk), .cpu_resetn_i(rst_n), .flush_i(flush),
    .lsu_vld_i(vld), .lsu_busy_o(d0_busy), .lsu_rob_i(rob), .lsu_op_i(op),
    .lsu_data_i(data), .lsu_addr_i(addr), .lsu_dest_i(dest),
    .lq_full_i(lq_full), .enqueue_full_i(enq_full),
    .lq_valid_o(d0_lq_valid), .lq_addr_o(d0_lq_addr), .lq_ld_type_o(d0_lq_type),
    .lq_dest_o(d0_lq_dest), .lq_rob_o(d0_lq_rob), .lq_part_o(d0_lq_part),
    .enqueue_en_o(d0_enq_en), .enqueue_address_o(d0_enq_addr), .enqueue_data_o(d0_enq_data),
    .enqueue_bm_o(d0_enq_bm), .enqueue_io_o(d0_enq_io), .enqueue_rob_o(d0_enq_rob),
    .conflict_address_o(d0_cf_addr), .conflict_bm_o(d0_cf_bm),
    .excp_valid(d0_x_valid), .excp_pc(d0_x_pc), .excp_code_o(d0_x_code), .excp_rob(d0_x_rob)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single cycle; outputs are checked right after the capturing edge.
  task automatic issue(input logic [3:0] i_op, input logic [31:0] i_addr,
                       input logic [31:0] i_data, input logic [5:0] i_rob,
                       input logic [5:0] i_dest);
    vld  = 1'b1;
    op   = i_op;
    addr = i_addr;
    data = i_data;
    rob  = i_rob;
    dest = i_dest;
    tick();
    vld  = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_lq_valid", 32'(lq_valid), 32'd0);
    chk("rst_enq_en",   32'(enq_en),   32'd0);
    chk("rst_excp",     32'(x_valid),  32'd0);
    chk("rst_part",     32'(lq_part),  32'd0);
    chk("rst_lq_addr",  lq_addr,       32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    rst_n = 1'b1;
    tick();

    // Aligned word store
    issue(4'b1010, 32'h0000_1000, 32'hDEAD_BEEF, 6'd5, 6'd0);
    chk("st_en",    32'(enq_en),   32'd1);
    chk("st_addr",  32'(enq_addr), 32'h400);
    chk("st_bm",    32'(enq_bm),   32'hF);
    chk("st_data",  enq_data,      32'hDEAD_BEEF);
    chk("st_io",    32'(enq_io),   32'd0);
    chk("st_rob",   32'(enq_rob),  32'd5);
    chk("st_lqv",   32'(lq_valid), 32'd0);
    tick();
    chk("st_en_clr", 32'(enq_en),  32'd0);

    // Unaligned byte store, no crossing
    issue(4'b1000, 32'h0000_2003, 32'h0000_00AB, 6'd6, 6'd0);
    chk("stb_bm",   32'(enq_bm),   32'h8);
    chk("stb_data", enq_data,      32'hAB00_0000);
    tick();

    // Word load crossing at 0x1002: two beats, one busy cycle
    issue(4'b0010, 32'h0000_1002, 32'h0, 6'd7, 6'd9);
    chk("ld0_valid", 32'(lq_valid), 32'd1);
    chk("ld0_addr",  lq_addr,       32'h1002);
    chk("ld0_part",  32'(lq_part),  32'h1);
    chk("ld0_cfbm",  32'(cf_bm),    32'hC);
    chk("ld0_cfad",  32'(cf_addr),  32'h400);
    chk("ld0_dest",  32'(lq_dest),  32'd9);
    chk("ld0_type",  32'(lq_type),  32'h2);
    chk("ld0_busy",  32'(busy),     32'd1);
    chk("d0_ld_x",   32'(d0_x_valid), 32'd1);
    chk("d0_ld_code", 32'(d0_x_code), 32'd4);
    tick();
    chk("ld1_valid", 32'(lq_valid), 32'd1);
    chk("ld1_addr",  lq_addr,       32'h1004);
    chk("ld1_part",  32'(lq_part),  32'h3);
    chk("ld1_cfbm",  32'(cf_bm),    32'h3);
    chk("ld1_cfad",  32'(cf_addr),  32'h401);
    chk("ld1_busy",  32'(busy),     32'd0);
    tick();
    chk("ld_clr",    32'(lq_valid), 32'd0);

    // Half store into the IO region: fault
    issue(4'b1001, 32'h8000_0003, 32'h0000_1234, 6'd3, 6'd0);
    chk("io_x",     32'(x_valid), 32'd1);
    chk("io_code",  32'(x_code),  32'd6);
    chk("io_pc",    x_pc,         32'h8000_0003);
    chk("io_rob",   32'(x_rob),   32'd3);
    chk("io_noenq", 32'(enq_en),  32'd0);
    tick();
    chk("io_x_clr", 32'(x_valid), 32'd0);

    // Split store, enqueue_full held for 3 cycles in SPLIT
    issue(4'b1010, 32'h0000_2001, 32'h1122_3344, 6'd10, 6'd0);
    chk("ss0_en",   32'(enq_en),   32'd1);
    chk("ss0_addr", 32'(enq_addr), 32'h800);
    chk("ss0_bm",   32'(enq_bm),   32'hE);
    chk("ss0_data", enq_data,      32'h2233_4400);
    enq_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ss_hold_en",   32'(enq_en),   32'd1);
      chk("ss_hold_addr", 32'(enq_addr), 32'h800);
      chk("ss_hold_busy", 32'(busy),     32'd1);
    end
    enq_full = 1'b0;
    tick();
    chk("ss1_en",   32'(enq_en),   32'd1);
    chk("ss1_addr", 32'(enq_addr), 32'h801);
    chk("ss1_bm",   32'(enq_bm),   32'h1);
    chk("ss1_data", enq_data,      32'h0000_0011);
    tick();
    chk("ss_nodup", 32'(enq_en),   32'd0);

    // Flush while in SPLIT: beat 1 discarded
    issue(4'b0010, 32'h0000_3002, 32'h0, 6'd12, 6'd1);
    chk("fl_b0",    32'(lq_part),  32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_lqv",   32'(lq_valid), 32'd0);
    chk("fl_enq",   32'(enq_en),   32'd0);
    chk("fl_busy",  32'(busy),     32'd0);
    tick();
    chk("fl_nob1",  32'(lq_valid), 32'd0);
    issue(4'b0110, 32'h0000_0100, 32'h0, 6'd13, 6'd2);
    chk("fl_idle_v",  32'(lq_valid), 32'd1);
    chk("fl_idle_pt", 32'(lq_part),  32'd0);
    chk("fl_idle_ty", 32'(lq_type),  32'h6);

    // Back-to-back aligned loads at full throughput
    issue(4'b0010, 32'h0000_0104, 32'h0, 6'd14, 6'd3);
    chk("b2b_addr", lq_addr,        32'h104);
    chk("b2b_rob",  32'(lq_rob),    32'd14);
    tick();

    // Top-of-address-space crossing load
    issue(4'b0010, 32'hFFFF_FFFE, 32'h0, 6'd15, 6'd4);
    chk("top_x",    32'(x_valid),  32'd1);
    chk("top_code", 32'(x_code),   32'd4);
    chk("top_pc",   x_pc,          32'hFFFF_FFFE);
    chk("top_nolq", 32'(lq_valid), 32'd0);
    tick();

    // Illegal size
    issue(4'b0011, 32'h0000_2000, 32'h0, 6'd16, 6'd5);
    chk("ill_x",    32'(x_valid), 32'd1);
    chk("ill_code", 32'(x_code),  32'd4);
    tick();

    // Half load at 0x1003: SPLIT_EN=0 faults, SPLIT_EN=1 splits
    issue(4'b0001, 32'h0000_1003, 32'h0, 6'd20, 6'd6);
    chk("h_d0_x",    32'(d0_x_valid), 32'd1);
    chk("h_d0_code", 32'(d0_x_code),  32'd4);
    chk("h_d0_pc",   d0_x_pc,         32'h1003);
    chk("h_d0_nolq", 32'(d0_lq_valid), 32'd0);
    chk("h_b0_part", 32'(lq_part),    32'h1);
    chk("h_b0_bm",   32'(cf_bm),      32'h8);
    tick();
    chk("h_b1_part", 32'(lq_part),    32'h3);
    chk("h_b1_bm",   32'(cf_bm),      32'h1);
    chk("h_b1_addr", lq_addr,         32'h1004);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
